// File: rtl/mem_port_arbiter.sv
// Arbitrates the single CPU memory port between instruction fetch and data access.
// Optional MEM_ARB_FAIR_EN: alternate grants on simultaneous requests (default: data wins).
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_ack,
  output logic [WORD_SIZE-1:0] if_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  logic [1:0]           state_q, state_nxt;
  logic                 owner_q, owner_nxt;
  logic                 we_q, we_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 done;
  logic                 grant_d;

  logic                 if_ack_nxt, d_ack_nxt;
  logic [WORD_SIZE-1:0] if_data_nxt, d_rdata_nxt;
  logic                 mem_read_nxt, mem_write_nxt;
  logic [WORD_SIZE-1:0] mem_addr_nxt, mem_wdata_nxt;
  logic                 busy_nxt, timeout_err_nxt;

`ifdef MEM_ARB_FAIR_EN
  logic last_grant_q;

  // On contention, grant whichever requester was not served last.
  always_comb begin
    grant_d = d_req && (!if_req || (last_grant_q == OWNER_IF));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= OWNER_IF;
    end else if ((state_q == IDLE) && (if_req || d_req)) begin
      last_grant_q <= grant_d ? OWNER_D : OWNER_IF;
    end
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state_q;
    owner_nxt       = owner_q;
    we_nxt          = we_q;
    cnt_nxt         = cnt_q;
    done            = 1'b0;
    if_ack_nxt      = 1'b0;
    d_ack_nxt       = 1'b0;
    if_data_nxt     = if_data;
    d_rdata_nxt     = d_rdata;
    mem_read_nxt    = mem_read;
    mem_write_nxt   = mem_write;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    timeout_err_nxt = timeout_err;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
          if (grant_d) begin
            owner_nxt     = OWNER_D;
            we_nxt        = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            mem_read_nxt  = !d_we;
            mem_write_nxt = d_we;
          end else begin
            owner_nxt     = OWNER_IF;
            we_nxt        = 1'b0;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = '0;
            mem_read_nxt  = 1'b1;
            mem_write_nxt = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (mem_ready) begin
          done = 1'b1;
          if (!we_q) begin
            if (owner_q == OWNER_D) d_rdata_nxt = mem_rdata;
            else                    if_data_nxt = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Stalled too long: abort and return zero read data.
          done            = 1'b1;
          timeout_err_nxt = 1'b1;
          if (!we_q) begin
            if (owner_q == OWNER_D) d_rdata_nxt = '0;
            else                    if_data_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end

        if (done) begin
          state_nxt     = RESP;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          if (owner_q == OWNER_D) d_ack_nxt  = 1'b1;
          else                    if_ack_nxt = 1'b1;
        end
      end

      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt == ACCESS) || (state_nxt == RESP);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_data     <= '0;
      d_rdata     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      owner_q     <= owner_nxt;
      we_q        <= we_nxt;
      cnt_q       <= cnt_nxt;
      if_ack      <= if_ack_nxt;
      d_ack       <= d_ack_nxt;
      if_data     <= if_data_nxt;
      d_rdata     <= d_rdata_nxt;
      mem_read    <= mem_read_nxt;
      mem_write   <= mem_write_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT overridden to 4).
module tb_mem_port_arbiter;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_ack;
  logic [W-1:0] if_data;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_ack;
  logic [W-1:0] d_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_ack"},  32'(if_ack), 32'd0);
    check({tag, ".d_ack"},   32'(d_ack), 32'd0);
    check({tag, ".if_data"}, 32'(if_data), 32'd0);
    check({tag, ".d_rdata"}, 32'(d_rdata), 32'd0);
    check({tag, ".rd"},      32'(mem_read), 32'd0);
    check({tag, ".wr"},      32'(mem_write), 32'd0);
    check({tag, ".addr"},    32'(mem_addr), 32'd0);
    check({tag, ".wdata"},   32'(mem_wdata), 32'd0);
    check({tag, ".busy"},    32'(busy), 32'd0);
    check({tag, ".err"},     32'(timeout_err), 32'd0);
  endtask

  // Fetch with memory ready one cycle after the strobe.
  task automatic do_fetch(input logic [W-1:0] addr, input logic [W-1:0] data, input string tag);
    if_req = 1'b1; if_addr = addr; mem_ready = 1'b0;
    step();
    check({tag, ".rd"},   32'(mem_read), 32'd1);
    check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
    mem_ready = 1'b1; mem_rdata = data;
    step();
    check({tag, ".ack"},  32'(if_ack), 32'd1);
    check({tag, ".data"}, 32'(if_data), 32'(data));
    check({tag, ".rd_drop"}, 32'(mem_read), 32'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    check({tag, ".ack_drop"}, 32'(if_ack), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // Basic fetch.
    do_fetch(16'h0010, 16'h1234, "fetch");

    // Data write, ready after two cycles; request fields change mid-access.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    step();
    check("wr.strobe", 32'(mem_write), 32'd1);
    check("wr.rd",     32'(mem_read), 32'd0);
    check("wr.addr",   32'(mem_addr), 32'h0040);
    check("wr.wdata",  32'(mem_wdata), 32'hBEEF);
    d_addr = 16'h0099; d_wdata = 16'h0000;
    step();
    check("wr.hold",       32'(mem_write), 32'd1);
    check("wr.addr_hold",  32'(mem_addr), 32'h0040);
    check("wr.wdata_hold", 32'(mem_wdata), 32'hBEEF);
    check("wr.rd2",        32'(mem_read), 32'd0);
    mem_ready = 1'b1;
    step();
    check("wr.drop", 32'(mem_write), 32'd0);
    check("wr.ack",  32'(d_ack), 32'd1);
    check("wr.if_ack", 32'(if_ack), 32'd0);
    check("wr.rd3",  32'(mem_read), 32'd0);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    step();
    check("wr.ack_drop", 32'(d_ack), 32'd0);

    // Simultaneous requests; last grant was data.
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
    step();
    check("both.rd", 32'(mem_read), 32'd1);
`ifdef MEM_ARB_FAIR_EN
    check("both.first_addr", 32'(mem_addr), 32'h0020);
    mem_ready = 1'b1; mem_rdata = 16'h6666;
    step();
    check("both.first_ack", 32'(if_ack), 32'd1);
    check("both.first_other", 32'(d_ack), 32'd0);
    check("both.first_data", 32'(if_data), 32'h6666);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    step();
    check("both.second_addr", 32'(mem_addr), 32'h0080);
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    step();
    check("both.second_ack", 32'(d_ack), 32'd1);
    check("both.second_data", 32'(d_rdata), 32'h5555);
    d_req = 1'b0; mem_ready = 1'b0;
`else
    check("both.first_addr", 32'(mem_addr), 32'h0080);
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    step();
    check("both.first_ack", 32'(d_ack), 32'd1);
    check("both.first_other", 32'(if_ack), 32'd0);
    check("both.first_data", 32'(d_rdata), 32'h5555);
    d_req = 1'b0; mem_ready = 1'b0;
    step();
    check("both.resp_rd", 32'(mem_read), 32'd0);
    step();
    check("both.second_rd", 32'(mem_read), 32'd1);
    check("both.second_addr", 32'(mem_addr), 32'h0020);
    mem_ready = 1'b1; mem_rdata = 16'h6666;
    step();
    check("both.second_ack", 32'(if_ack), 32'd1);
    check("both.second_data", 32'(if_data), 32'h6666);
    if_req = 1'b0; mem_ready = 1'b0;
`endif
    step();
    check("both.idle", 32'(busy), 32'd0);

    // Timeout on a fetch: strobe high for exactly 4 cycles.
    if_req = 1'b1; if_addr = 16'h0030; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("to.strobe%0d", i), 32'(mem_read), 32'd1);
      check($sformatf("to.noack%0d", i), 32'(if_ack), 32'd0);
    end
    step();
    check("to.drop", 32'(mem_read), 32'd0);
    check("to.ack",  32'(if_ack), 32'd1);
    check("to.data", 32'(if_data), 32'd0);
    check("to.err",  32'(timeout_err), 32'd1);
    if_req = 1'b0;
    step();
    check("to.ack_drop", 32'(if_ack), 32'd0);
    check("to.err_sticky", 32'(timeout_err), 32'd1);

    // Successful data read after timeout keeps the error flag.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    step();
    check("rd.strobe", 32'(mem_read), 32'd1);
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    step();
    check("rd.ack",  32'(d_ack), 32'd1);
    check("rd.data", 32'(d_rdata), 32'h7777);
    check("rd.err",  32'(timeout_err), 32'd1);
    d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Asynchronous reset in the middle of an access.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h1111;
    step();
    check("mid.strobe", 32'(mem_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    d_req = 1'b0; d_we = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("mid.idle", 32'(busy), 32'd0);
    do_fetch(16'h0070, 16'h8888, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
